// File: rtl/wb_commit_stage_if.sv
// Writeback/commit stage bus: MEM-side hand-off, CSR read data and RF ready in; commit pulses,
// latched cause/targets and the retire trace out.
interface wb_commit_stage_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned EXC_N  = 6,
    parameter int unsigned CNT_W  = 16
);
    logic                       mem_valid;
    logic                       wb_allowin;
    logic [PC_W-1:0]            mem_pc;
    logic                       mem_gr_we;
    logic [4:0]                 mem_rf_waddr;
    logic [DATA_W-1:0]          mem_rf_wdata;
    logic                       mem_csr_re;
    logic                       mem_csr_we;
    logic [13:0]                mem_csr_num;
    logic [DATA_W-1:0]          mem_csr_wmask;
    logic [DATA_W-1:0]          mem_csr_wvalue;
    logic                       mem_ertn;
    logic [EXC_N-1:0]           mem_exc_vec;
    logic [PC_W-1:0]            mem_vaddr;
    logic [DATA_W-1:0]          csr_rvalue;
    logic                       rf_wready;

    logic                       csr_re;
    logic [13:0]                csr_num;
    logic                       csr_we;
    logic [DATA_W-1:0]          csr_wmask;
    logic [DATA_W-1:0]          csr_wvalue;
    logic                       rf_wen;
    logic [4:0]                 rf_waddr;
    logic [DATA_W-1:0]          rf_wdata;
    logic                       wb_ex;
    logic [5:0]                 wb_ecode;
    logic [8:0]                 wb_esubcode;
    logic [PC_W-1:0]            wb_pc;
    logic [PC_W-1:0]            wb_vaddr;
    logic                       ertn_flush;
    logic [PC_W+4+5+DATA_W-1:0] inst_retire;
    logic [CNT_W-1:0]           retire_cnt;

    modport master (
        output mem_valid, mem_pc, mem_gr_we, mem_rf_waddr, mem_rf_wdata, mem_csr_re, mem_csr_we,
               mem_csr_num, mem_csr_wmask, mem_csr_wvalue, mem_ertn, mem_exc_vec, mem_vaddr,
               csr_rvalue, rf_wready,
        input  wb_allowin, csr_re, csr_num, csr_we, csr_wmask, csr_wvalue, rf_wen, rf_waddr,
               rf_wdata, wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_vaddr, ertn_flush, inst_retire,
               retire_cnt
    );

    modport slave (
        input  mem_valid, mem_pc, mem_gr_we, mem_rf_waddr, mem_rf_wdata, mem_csr_re, mem_csr_we,
               mem_csr_num, mem_csr_wmask, mem_csr_wvalue, mem_ertn, mem_exc_vec, mem_vaddr,
               csr_rvalue, rf_wready,
        output wb_allowin, csr_re, csr_num, csr_we, csr_wmask, csr_wvalue, rf_wen, rf_waddr,
               rf_wdata, wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_vaddr, ertn_flush, inst_retire,
               retire_cnt
    );
endinterface

// File: rtl/wb_commit_stage.sv
// Writeback/commit stage: holds one instruction from MEM, waits out multi-cycle CSR reads and
// RF-port backpressure, then emits single-cycle commit pulses and the retire trace.
module wb_commit_stage #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned PC_W    = 32,
    parameter int unsigned EXC_N   = 6,
    parameter int unsigned CSR_LAT = 1,
    parameter int unsigned CNT_W   = 16
) (
    input logic              clk,
    input logic              rst,
    wb_commit_stage_if.slave wb
);
    localparam logic [1:0] StEmpty   = 2'd0;
    localparam logic [1:0] StCsrWait = 2'd1;
    localparam logic [1:0] StHold    = 2'd2;

    localparam int unsigned       WaitW    = (CSR_LAT < 2) ? 1 : $clog2(CSR_LAT + 1);
    localparam logic [WaitW-1:0]  WaitInit = WaitW'(CSR_LAT);
    localparam logic [WaitW-1:0]  WaitLast = WaitW'(1);
    localparam logic [CNT_W-1:0]  CntOne   = CNT_W'(1);
    localparam logic              HasWait  = (CSR_LAT != 0);

    logic [1:0]        state_q, state_d;
    logic [WaitW-1:0]  wait_q, wait_d;
    logic [PC_W-1:0]   pc_q, vaddr_q;
    logic              gr_we_q, csr_re_q, csr_we_q, ertn_q;
    logic [4:0]        waddr_q;
    logic [DATA_W-1:0] wdata_q, wmask_q, wvalue_q;
    logic [13:0]       csr_num_q;
    logic [EXC_N-1:0]  exc_q;
    logic [CNT_W-1:0]  retire_cnt_q;

    logic              ex, mem_ex, commit_ok, allowin, transfer, csr_capture, rf_wen;
    logic [DATA_W-1:0] rf_wdata;
    logic [5:0]        ecode;

    assign ex          = |exc_q;
    assign mem_ex      = |wb.mem_exc_vec;
    // Reset suppresses the commit so an entry caught by reset leaves no trace.
    assign commit_ok   = ~rst & (state_q == StHold) & (ex | ~gr_we_q | wb.rf_wready);
    assign allowin     = ~rst & ((state_q == StEmpty) | commit_ok);
    assign transfer    = wb.mem_valid & allowin;
    assign csr_capture = (state_q == StCsrWait) & (wait_q == WaitLast);

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            StEmpty, StHold: begin
                if (transfer) begin
                    if (wb.mem_csr_re & ~mem_ex & HasWait) begin
                        state_d = StCsrWait;
                        wait_d  = WaitInit;
                    end else begin
                        state_d = StHold;
                    end
                end else if (commit_ok) begin
                    state_d = StEmpty;
                end
            end
            StCsrWait: begin
                wait_d = wait_q - WaitLast;
                if (csr_capture) begin
                    state_d = StHold;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StEmpty;
            wait_q       <= '0;
            pc_q         <= '0;
            vaddr_q      <= '0;
            gr_we_q      <= 1'b0;
            csr_re_q     <= 1'b0;
            csr_we_q     <= 1'b0;
            ertn_q       <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            wvalue_q     <= '0;
            csr_num_q    <= '0;
            exc_q        <= '0;
            retire_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if (transfer) begin
                pc_q      <= wb.mem_pc;
                vaddr_q   <= wb.mem_vaddr;
                gr_we_q   <= wb.mem_gr_we;
                csr_re_q  <= wb.mem_csr_re;
                csr_we_q  <= wb.mem_csr_we;
                ertn_q    <= wb.mem_ertn;
                waddr_q   <= wb.mem_rf_waddr;
                wdata_q   <= wb.mem_rf_wdata;
                wmask_q   <= wb.mem_csr_wmask;
                wvalue_q  <= wb.mem_csr_wvalue;
                csr_num_q <= wb.mem_csr_num;
                exc_q     <= wb.mem_exc_vec;
            end else if (csr_capture) begin
                wdata_q <= wb.csr_rvalue;
            end
            if (commit_ok & ~ex) begin
                retire_cnt_q <= retire_cnt_q + CntOne;
            end
        end
    end

    function automatic logic [5:0] exc_cause(input int idx);
        case (idx)
            1:       return 6'h08;
            2:       return 6'h0D;
            3:       return 6'h0B;
            4:       return 6'h0C;
            5:       return 6'h09;
            default: return 6'h00;
        endcase
    endfunction

    // Scan from the top so the lowest set index wins.
    always_comb begin
        ecode = 6'h00;
        for (int i = int'(EXC_N) - 1; i >= 0; i--) begin
            if (exc_q[i]) begin
                ecode = exc_cause(i);
            end
        end
    end

    // With no wait states the CSR read data is consumed live during HOLD.
    assign rf_wdata = (!HasWait && csr_re_q && !ex) ? wb.csr_rvalue : wdata_q;
    assign rf_wen   = commit_ok & gr_we_q & ~ex;

    assign wb.wb_allowin  = allowin;
    assign wb.csr_re      = (state_q != StEmpty) & csr_re_q & ~ex;
    assign wb.csr_num     = csr_num_q;
    assign wb.csr_we      = commit_ok & csr_we_q & ~ex;
    assign wb.csr_wmask   = wmask_q;
    assign wb.csr_wvalue  = wvalue_q;
    assign wb.rf_wen      = rf_wen;
    assign wb.rf_waddr    = waddr_q;
    assign wb.rf_wdata    = rf_wdata;
    assign wb.wb_ex       = commit_ok & ex;
    assign wb.wb_ecode    = ecode;
    assign wb.wb_esubcode = 9'd0;
    assign wb.wb_pc       = pc_q;
    assign wb.wb_vaddr    = vaddr_q;
    assign wb.ertn_flush  = commit_ok & ertn_q & ~ex;
    assign wb.inst_retire = {pc_q, {4{rf_wen}}, waddr_q, rf_wdata};
    assign wb.retire_cnt  = retire_cnt_q;
endmodule
